// File: rtl/disp_pkg.sv
// Shared code constants, enums and the double-dabble step used by the display scheduler.
package disp_pkg;

  localparam int VAL_W     = 10;
  localparam int BCD_W     = 12;
  localparam int SH_W      = BCD_W + VAL_W;
  localparam int CONV_ITER = 10;

  localparam logic [VAL_W-1:0] VAL_MAX    = 10'd999;
  localparam logic [3:0]       CODE_E     = 4'd10;
  localparam logic [3:0]       CODE_BLANK = 4'd15;

  typedef enum logic [1:0] {
    FMT_NUM   = 2'd0,
    FMT_E     = 2'd1,
    FMT_BLANK = 2'd2,
    FMT_RSVD  = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_HUND = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_LOAD  = 2'd1,
    CONV_SHIFT = 2'd2,
    CONV_DONE  = 2'd3
  } conv_e;

  // One shift-add-3 iteration over {bcd[11:0], bin[9:0]}.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[VAL_W+4*k +: 4] >= 4'd5) t[VAL_W+4*k +: 4] = t[VAL_W+4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter; first iteration runs on the start edge,
// so done is high on the cycle after the tenth iteration.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [VAL_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [SH_W-1:0] sh_q, sh_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i && !busy_q) begin
      sh_d   = dd_step({{BCD_W{1'b0}}, bin_i});
      cnt_d  = 4'(CONV_ITER - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != 4'd0) begin
        sh_d  = dd_step(sh_q);
        cnt_d = cnt_q - 4'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 4'd0);
  assign bcd_o  = sh_q[SH_W-1:VAL_W];

endmodule

// File: rtl/disp_sched.sv
// Shares the 3-digit display between requesters: scan divider, held-priority arbiter,
// sequential BCD conversion into a double buffer, and blanked digit multiplexing.
//   state      | meaning
//   CONV_IDLE  | waiting for frame_end
//   CONV_LOAD  | start converter with the granted (saturated) value, latch format
//   CONV_SHIFT | converter iterating
//   CONV_DONE  | copy result and format into the display buffer
module disp_sched
  import disp_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int HOLD_FRM  = 200,
  parameter int LZ_BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [10*NREQ-1:0]    val_bus,
  input  logic [2*NREQ-1:0]     fmt_bus,
  output logic [NREQ-1:0]       grant,
  output logic [3:0]            num_code,
  output logic [2:0]            seg_sel,
  output logic                  frame_end
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRM + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRM - 1);

  logic [DW-1:0]    div_q, div_d;
  slot_e            slot_q, slot_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [HW-1:0]    hold_q, hold_d;
  conv_e            state_q, state_d;
  fmt_e             lat_fmt_q, lat_fmt_d;
  logic             lat_none_q, lat_none_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  fmt_e             disp_fmt_q, disp_fmt_d;

  logic             frame_end_w, owner_live, conv_start, conv_busy, conv_done;
  logic [NREQ-1:0]  win_oh;
  logic [VAL_W-1:0] val_sel, val_sat;
  fmt_e             fmt_sel;
  logic [BCD_W-1:0] conv_bcd;

  assign frame_end_w = (div_q == DIV_LAST) && (slot_q == SLOT_HUND);

  always_comb begin
    div_d  = div_q + DW'(1);
    slot_d = slot_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: slot_d = SLOT_HUND;
        default:   slot_d = SLOT_ONES;
      endcase
    end
  end

  // Lowest set bit of req wins.
  assign win_oh     = req & (~req + NREQ'(1));
  assign owner_live = |(grant_q & req);

  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_q;
    if (frame_end_w) begin
      if (owner_live && (hold_q != '0)) begin
        hold_d = hold_q - HW'(1);
      end else if (req == '0) begin
        grant_d = '0;
        hold_d  = '0;
      end else if (win_oh != grant_q) begin
        grant_d = win_oh;
        hold_d  = HOLD_LOAD;
      end
    end
  end

  always_comb begin
    val_sel = '0;
    fmt_sel = FMT_BLANK;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        val_sel = val_bus[10*i +: 10];
        fmt_sel = fmt_e'(fmt_bus[2*i +: 2]);
      end
    end
    val_sat = (val_sel > VAL_MAX) ? VAL_MAX : val_sel;
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    lat_fmt_d  = lat_fmt_q;
    lat_none_d = lat_none_q;
    disp_bcd_d = disp_bcd_q;
    disp_fmt_d = disp_fmt_q;
    case (state_q)
      CONV_IDLE: if (frame_end_w) state_d = CONV_LOAD;
      CONV_LOAD: begin
        conv_start = 1'b1;
        lat_fmt_d  = fmt_sel;
        lat_none_d = (grant_q == '0);
        state_d    = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        if (conv_done)      state_d = CONV_DONE;
        else if (!conv_busy) state_d = CONV_IDLE;
      end
      default: begin
        disp_bcd_d = conv_bcd;
        disp_fmt_d = lat_none_q ? FMT_BLANK : lat_fmt_q;
        state_d    = CONV_IDLE;
      end
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (val_sat),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      slot_q     <= SLOT_ONES;
      grant_q    <= '0;
      hold_q     <= '0;
      state_q    <= CONV_IDLE;
      lat_fmt_q  <= FMT_BLANK;
      lat_none_q <= 1'b1;
      disp_bcd_q <= '0;
      disp_fmt_q <= FMT_BLANK;
    end else begin
      div_q      <= div_d;
      slot_q     <= slot_d;
      grant_q    <= grant_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      lat_fmt_q  <= lat_fmt_d;
      lat_none_q <= lat_none_d;
      disp_bcd_q <= disp_bcd_d;
      disp_fmt_q <= disp_fmt_d;
    end
  end

  logic [2:0] sel_oh;
  logic [3:0] dig;
  logic       lead_h, lz;

  assign lead_h = (LZ_BLANK != 0) && (disp_bcd_q[11:8] == 4'd0);

  always_comb begin
    seg_sel  = 3'b000;
    num_code = CODE_BLANK;
    case (slot_q)
      SLOT_TENS: begin
        sel_oh = 3'b010;
        dig    = disp_bcd_q[7:4];
        lz     = lead_h && (disp_bcd_q[7:4] == 4'd0);
      end
      SLOT_HUND: begin
        sel_oh = 3'b100;
        dig    = disp_bcd_q[11:8];
        lz     = lead_h;
      end
      default: begin
        sel_oh = 3'b001;
        dig    = disp_bcd_q[3:0];
        lz     = 1'b0;
      end
    endcase
    if (div_q >= BLANK_END) begin
      seg_sel = sel_oh;
      case (disp_fmt_q)
        FMT_NUM: num_code = lz ? CODE_BLANK : dig;
        FMT_E:   num_code = CODE_E;
        default: num_code = CODE_BLANK;
      endcase
    end
  end

  assign grant     = grant_q;
  assign frame_end = frame_end_w;

endmodule

// File: tb/tb_disp_sched.sv
// Randomized and directed checks of disp_sched against a frame-level reference model.
module tb_disp_sched;

  localparam int NREQ      = 4;
  localparam int SCAN_DIV  = 10;
  localparam int BLANK_CYC = 2;
  localparam int HOLD_FRM  = 3;
  localparam int FRAME     = 3 * SCAN_DIV;
  localparam int LATENCY   = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [10*NREQ-1:0]   val_bus = '0;
  logic [2*NREQ-1:0]    fmt_bus = '0;
  logic [NREQ-1:0]      grant;
  logic [3:0]           num_code;
  logic [2:0]           seg_sel;
  logic                 frame_end;

  always #5 clk = ~clk;

  disp_sched #(
    .NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .HOLD_FRM(HOLD_FRM), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val_bus(val_bus), .fmt_bus(fmt_bus),
    .grant(grant), .num_code(num_code), .seg_sel(seg_sel), .frame_end(frame_end)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in frame, owner index, hold frames, pending/shown content.
  int p, m_owner, m_hold, m_cd;
  int pend_v, pend_fmt, disp_v, disp_fmt;
  bit pend_none, disp_none;

  task automatic model_reset();
    p = 0; m_owner = -1; m_hold = 0; m_cd = 0;
    disp_none = 1'b1; disp_fmt = 2; disp_v = 0;
    pend_none = 1'b1; pend_fmt = 2; pend_v = 0;
  endtask

  function automatic int exp_code(input int slot);
    if (disp_none || disp_fmt >= 2) return 15;
    if (disp_fmt == 1) return 10;
    case (slot)
      0:       return disp_v % 10;
      1:       return (disp_v < 10) ? 15 : (disp_v / 10) % 10;
      default: return (disp_v < 100) ? 15 : disp_v / 100;
    endcase
  endfunction

  task automatic check_now();
    int in_slot, slot;
    in_slot = p % SCAN_DIV;
    slot    = p / SCAN_DIV;
    chk("grant", 32'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
    chk("frame_end", 32'(frame_end), (p == FRAME - 1) ? 1 : 0);
    chk("seg_sel", 32'(seg_sel), (in_slot < BLANK_CYC) ? 0 : (1 << slot));
    chk("num_code", 32'(num_code), (in_slot < BLANK_CYC) ? 15 : exp_code(slot));
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int lo, v;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        disp_none = pend_none; disp_fmt = pend_fmt; disp_v = pend_v;
      end
    end
    if (p == FRAME - 1) begin
      lo = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (req[i]) lo = i;
      if (m_owner >= 0 && req[m_owner] && m_hold > 0) m_hold--;
      else if (lo < 0) begin m_owner = -1; m_hold = 0; end
      else if (lo != m_owner) begin m_owner = lo; m_hold = HOLD_FRM - 1; end
      pend_none = (m_owner < 0);
      if (m_owner >= 0) begin
        v = int'(val_bus[10*m_owner +: 10]);
        pend_v   = (v > 999) ? 999 : v;
        pend_fmt = int'(fmt_bus[2*m_owner +: 2]);
      end
      m_cd = LATENCY;
    end
    p = (p + 1) % FRAME;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
  endtask

  task automatic run(input int n);
    repeat (n) begin cyc(); model_step(); end
  endtask

  // Leaves the bench in the drive slot of the cycle at frame position target.
  task automatic advance_to(input int target);
    for (int k = 0; k <= FRAME; k++) begin
      cyc();
      if (p == target) return;
      model_step();
    end
    chk("advance_to", 32'(p), 32'(target));
  endtask

  task automatic set_in(input int idx, input int v, input int f);
    val_bus[10*idx +: 10] = 10'(v);
    fmt_bus[2*idx +: 2]   = 2'(f);
  endtask

  int vals[9] = '{1023, 7, 0, 999, 100, 10, 99, 1000, 5};

  initial begin
    model_reset();
    for (int i = 1; i < NREQ; i++) set_in(i, int'($urandom_range(0, 1023)), 0);
    set_in(0, 507, 0);
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check_now();
    rst_n = 1'b1;
    check_now();
    model_step();
    run(2 * FRAME + 20);

    foreach (vals[i]) begin
      advance_to(5); set_in(0, vals[i], 0); model_step(); run(2 * FRAME);
    end

    // Held owner vs higher-priority newcomer.
    advance_to(5); req = 4'b0000; model_step(); run(FRAME);
    advance_to(5); req = 4'b0100; set_in(2, 321, 0); model_step(); run(FRAME);
    advance_to(5); req = 4'b0101; model_step(); run(4 * FRAME);

    // Owner drops mid-frame while still holding.
    advance_to(5); req = 4'b0000; model_step(); run(FRAME);
    advance_to(5); req = 4'b0100; model_step(); run(FRAME);
    advance_to(5); req = 4'b1000; set_in(3, 42, 0); model_step(); run(2 * FRAME);
    advance_to(FRAME - 1); req = 4'b0001; model_step(); run(2 * FRAME);

    // Formats and no request.
    advance_to(5); set_in(0, 555, 1); model_step(); run(2 * FRAME);
    advance_to(5); set_in(0, 555, 3); model_step(); run(2 * FRAME);
    advance_to(5); req = 4'b0000; model_step(); run(2 * FRAME);

    for (int c = 0; c < 40 * FRAME; c++) begin
      cyc();
      if (p >= 2 && p <= 20 && $urandom_range(0, 9) == 0)
        set_in(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
      model_step();
    end

    // Asynchronous reset in the middle of a conversion.
    advance_to(5); req = 4'b0001; set_in(0, 888, 0); model_step(); run(2 * FRAME);
    advance_to(FRAME - 1); model_step(); run(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_now();
    @(negedge clk);
    rst_n = 1'b1;
    check_now();
    model_step();
    run(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
